// File: rtl/reg_file_mp_pkg.sv
// Shared parameters and encodings for the multi-port register file.
//   WIDTH_DEF / NUM_REGS_DEF / REG_ADDR_LEN_DEF / NUM_RD_DEF : default sizing
//   wmode_e : write-mode encoding carried on wr_mode
package reg_file_mp_pkg;

  localparam int unsigned WIDTH_DEF        = 32;
  localparam int unsigned NUM_REGS_DEF     = 32;
  localparam int unsigned REG_ADDR_LEN_DEF = 5;
  localparam int unsigned NUM_RD_DEF       = 2;

  typedef enum logic [1:0] {
    WMODE_WORD = 2'd0,
    WMODE_HALF = 2'd1,
    WMODE_BYTE = 2'd2,
    WMODE_RSVD = 2'd3
  } wmode_e;

endpackage

// File: rtl/wr_extend.sv
// Write-data extender: produces the word actually stored for a write.
//   wr_data    : raw write data
//   wr_mode    : word / halfword / byte / reserved
//   wr_sext    : 1 = sign-extend halfword/byte, 0 = zero-extend
//   ext_data_c : extended word (combinational); 0 for the reserved mode
module wr_extend
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       wr_mode,
  input  logic             wr_sext,
  output logic [WIDTH-1:0] ext_data_c
);

  logic [WIDTH-1:0] half_ext;
  logic [WIDTH-1:0] byte_ext;

  // Size casts of a signed operand sign-extend; of an unsigned one zero-extend.
  always_comb begin
    half_ext = wr_sext ? WIDTH'($signed(wr_data[15:0])) : WIDTH'(wr_data[15:0]);
    byte_ext = wr_sext ? WIDTH'($signed(wr_data[7:0]))  : WIDTH'(wr_data[7:0]);
  end

  always_comb begin
    ext_data_c = '0;
    case (wr_mode)
      WMODE_WORD: ext_data_c = wr_data;
      WMODE_HALF: ext_data_c = half_ext;
      WMODE_BYTE: ext_data_c = byte_ext;
      default:    ext_data_c = '0;
    endcase
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a pending-write scoreboard.
//   clk, rst          : clock, asynchronous active-high reset
//   rd_en/rd_addr     : per-port read request and address (packed by port)
//   rd_data/rd_valid  : registered read data and valid strobe, one cycle
//   rd_busy           : read rejected because the register is pending
//   wr_en/wr_addr/wr_data/wr_mode/wr_sext : write with width/extension
//   rsv_en/rsv_addr   : mark a register pending
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned WIDTH        = WIDTH_DEF,
  parameter int unsigned NUM_REGS     = NUM_REGS_DEF,
  parameter int unsigned REG_ADDR_LEN = REG_ADDR_LEN_DEF,
  parameter int unsigned NUM_RD       = NUM_RD_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD*REG_ADDR_LEN-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]        rd_data,
  output logic [NUM_RD-1:0]              rd_valid,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic                           wr_en,
  input  logic [REG_ADDR_LEN-1:0]        wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic [1:0]                     wr_mode,
  input  logic                           wr_sext,
  input  logic                           rsv_en,
  input  logic [REG_ADDR_LEN-1:0]        rsv_addr
);

  logic [WIDTH-1:0]        regs_q [NUM_REGS];
  logic [WIDTH-1:0]        regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]     pend_q;
  logic [NUM_REGS-1:0]     pend_d;
  logic [NUM_RD*WIDTH-1:0] rd_data_q;
  logic [NUM_RD*WIDTH-1:0] rd_data_d;
  logic [NUM_RD-1:0]       rd_valid_q;
  logic [NUM_RD-1:0]       rd_valid_d;
  logic [NUM_RD-1:0]       rd_busy_q;
  logic [NUM_RD-1:0]       rd_busy_d;

  logic [WIDTH-1:0]        wr_ext_c;
  logic                    wr_commit_c;
  logic [REG_ADDR_LEN-1:0] rd_addr_a [NUM_RD];

  // Single extender feeds both the commit path and the read bypass.
  wr_extend #(.WIDTH(WIDTH)) u_wr_extend (
    .wr_data    (wr_data),
    .wr_mode    (wr_mode),
    .wr_sext    (wr_sext),
    .ext_data_c (wr_ext_c)
  );

  for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd_addr
    assign rd_addr_a[g] = rd_addr[g*REG_ADDR_LEN +: REG_ADDR_LEN];
  end

  // Address 0 is hard-wired to zero, so it never commits.
  assign wr_commit_c = wr_en && (wr_mode != WMODE_RSVD) && (wr_addr != '0);

  // File and scoreboard next state; reservation is applied last so set wins.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_commit_c) begin
      regs_d[wr_addr] = wr_ext_c;
      pend_d[wr_addr] = 1'b0;
    end
    if (rsv_en && (rsv_addr != '0)) begin
      pend_d[rsv_addr] = 1'b1;
    end
  end

  // Per-port read: same-edge write bypass first, then pending check.
  // Register 0 is never written or reserved, so it always reads valid zero.
  always_comb begin
    rd_data_d  = '0;
    rd_valid_d = '0;
    rd_busy_d  = '0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      if (rd_en[p]) begin
        if (wr_commit_c && (rd_addr_a[p] == wr_addr)) begin
          rd_valid_d[p]              = 1'b1;
          rd_data_d[p*WIDTH +: WIDTH] = wr_ext_c;
        end else if (pend_q[rd_addr_a[p]]) begin
          rd_busy_d[p] = 1'b1;
        end else begin
          rd_valid_d[p]              = 1'b1;
          rd_data_d[p*WIDTH +: WIDTH] = regs_q[rd_addr_a[p]];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      pend_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      rd_busy_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_busy_q  <= rd_busy_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_busy  = rd_busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp (default parameters, two read ports).
module tb_reg_file_mp;

  localparam int unsigned W  = 32;
  localparam int unsigned AL = 5;
  localparam int unsigned NR = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    rd_en;
  logic [NR*AL-1:0] rd_addr;
  logic [NR*W-1:0]  rd_data;
  logic [NR-1:0]    rd_valid;
  logic [NR-1:0]    rd_busy;
  logic             wr_en;
  logic [AL-1:0]    wr_addr;
  logic [W-1:0]     wr_data;
  logic [1:0]       wr_mode;
  logic             wr_sext;
  logic             rsv_en;
  logic [AL-1:0]    rsv_addr;

  typedef struct {
    string       name;
    logic [67:0] e;   // {valid[1:0], busy[1:0], data1, data0}
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_mode  (wr_mode),
    .wr_sext  (wr_sext),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr)
  );

  // Monitor: every presented response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ((|rd_valid) || (|rd_busy))) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got v=%b b=%b d=%h, required no output",
                 rd_valid, rd_busy, rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rd_valid, rd_busy, rd_data} !== mon_e.e) begin
          errors++;
          $display("FAIL %s: got v=%b b=%b d=%h, required v=%b b=%b d=%h",
                   mon_e.name, rd_valid, rd_busy, rd_data,
                   mon_e.e[67:66], mon_e.e[65:64], mon_e.e[63:0]);
        end
      end
    end
  end

  task automatic clear_inputs();
    rd_en    = '0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_mode  = 2'd0;
    wr_sext  = 1'b0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  // One clock of stimulus; a read pushes its expected response.
  task automatic cyc(input string nm,
                     input logic [1:0] ren, input logic [4:0] a0, input logic [4:0] a1,
                     input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [1:0] wm, input logic ws,
                     input logic rs, input logic [4:0] ra,
                     input logic [1:0] ev, input logic [1:0] eb,
                     input logic [31:0] e0, input logic [31:0] e1);
    exp_t x;
    rd_en    = ren;
    rd_addr  = {a1, a0};
    wr_en    = wen;
    wr_addr  = wa;
    wr_data  = wd;
    wr_mode  = wm;
    wr_sext  = ws;
    rsv_en   = rs;
    rsv_addr = ra;
    if (ren != 2'b00) begin
      x.name = nm;
      x.e    = {ev, eb, e1, e0};
      exp_q.push_back(x);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ((rd_valid !== '0) || (rd_busy !== '0) || (rd_data !== '0)) begin
      errors++;
      $display("FAIL %s: got v=%b b=%b d=%h, required all zero", nm, rd_valid, rd_busy, rd_data);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #1;
    check_zero("reset_outputs");
    // Activity while reset is held must be ignored.
    #1;
    rd_en = 2'b11; rd_addr = {5'd13, 5'd13};
    wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'h000000AB; wr_mode = 2'd0;
    rsv_en = 1'b1; rsv_addr = 5'd14;
    #10;
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);

    //  name             ren    a0 a1  we wa  wdata          wm ws  rs ra  ev     eb     e0             e1
    cyc("rst_read5",     2'b11, 5, 5,  0, 0,  32'h0,         0, 0,  0, 0,  2'b11, 2'b00, 32'h0,         32'h0);
    cyc("rst_ignored",   2'b11, 13,14, 0, 0,  32'h0,         0, 0,  0, 0,  2'b11, 2'b00, 32'h0,         32'h0);
    cyc("w3_byte_sx",    2'b00, 0, 0,  1, 3,  32'h000000F0,  2, 1,  0, 0,  2'b00, 2'b00, 32'h0,         32'h0);
    cyc("r3_byte_sx",    2'b01, 3, 0,  0, 0,  32'h0,         0, 0,  0, 0,  2'b01, 2'b00, 32'hFFFFFFF0,  32'h0);
    cyc("w3_byte_zx",    2'b00, 0, 0,  1, 3,  32'h000000F0,  2, 0,  0, 0,  2'b00, 2'b00, 32'h0,         32'h0);
    cyc("r3_byte_zx",    2'b11, 3, 3,  0, 0,  32'h0,         0, 0,  0, 0,  2'b11, 2'b00, 32'h000000F0,  32'h000000F0);
    cyc("w3_half_sx",    2'b00, 0, 0,  1, 3,  32'h12348000,  1, 1,  0, 0,  2'b00, 2'b00, 32'h0,         32'h0);
    cyc("r3_half_sx",    2'b10, 0, 3,  0, 0,  32'h0,         0, 0,  0, 0,  2'b10, 2'b00, 32'h0,         32'hFFFF8000);
    cyc("bypass_w7",     2'b11, 7, 7,  1, 7,  32'hDEADBEEF,  0, 0,  0, 0,  2'b11, 2'b00, 32'hDEADBEEF,  32'hDEADBEEF);
    cyc("rsv9",          2'b00, 0, 0,  0, 0,  32'h0,         0, 0,  1, 9,  2'b00, 2'b00, 32'h0,         32'h0);
    cyc("busy9",         2'b11, 9, 9,  0, 0,  32'h0,         0, 0,  0, 0,  2'b00, 2'b11, 32'h0,         32'h0);
    cyc("bypass_w9",     2'b01, 9, 0,  1, 9,  32'h00000055,  0, 0,  0, 0,  2'b01, 2'b00, 32'h00000055,  32'h0);
    cyc("r9_after",      2'b11, 9, 9,  0, 0,  32'h0,         0, 0,  0, 0,  2'b11, 2'b00, 32'h00000055,  32'h00000055);
    cyc("w0_rsv0",       2'b00, 0, 0,  1, 0,  32'hFFFFFFFF,  0, 0,  1, 0,  2'b00, 2'b00, 32'h0,         32'h0);
    cyc("r0",            2'b11, 0, 0,  0, 0,  32'h0,         0, 0,  0, 0,  2'b11, 2'b00, 32'h0,         32'h0);
    cyc("w4_word",       2'b00, 0, 0,  1, 4,  32'h11112222,  0, 0,  0, 0,  2'b00, 2'b00, 32'h0,         32'h0);
    cyc("w4_rsvd",       2'b00, 0, 0,  1, 4,  32'hAAAAAAAA,  3, 1,  0, 0,  2'b00, 2'b00, 32'h0,         32'h0);
    cyc("r4_rsvd_mode",  2'b01, 4, 0,  0, 0,  32'h0,         0, 0,  0, 0,  2'b01, 2'b00, 32'h11112222,  32'h0);
    cyc("rsv_wr_same10", 2'b01, 10,0,  1, 10, 32'h00000077,  0, 0,  1, 10, 2'b01, 2'b00, 32'h00000077,  32'h0);
    cyc("busy10",        2'b01, 10,0,  0, 0,  32'h0,         0, 0,  0, 0,  2'b00, 2'b01, 32'h0,         32'h0);
    cyc("w10_rsvd",      2'b00, 0, 0,  1, 10, 32'h12345678,  3, 0,  0, 0,  2'b00, 2'b00, 32'h0,         32'h0);
    cyc("rersv10",       2'b10, 0, 10, 0, 0,  32'h0,         0, 0,  1, 10, 2'b00, 2'b10, 32'h0,         32'h0);
    cyc("bypass_half6",  2'b10, 0, 6,  1, 6,  32'h12348000,  1, 0,  0, 0,  2'b10, 2'b00, 32'h0,         32'h00008000);
    cyc("mixed_ports",   2'b11, 7, 10, 0, 0,  32'h0,         0, 0,  0, 0,  2'b01, 2'b10, 32'hDEADBEEF,  32'h0);
    cyc("w11",           2'b00, 0, 0,  1, 11, 32'h00000099,  0, 0,  1, 12, 2'b00, 2'b00, 32'h0,         32'h0);

    // Reset asserted between edges while a read response is on the outputs.
    rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_async_clear");
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;

    cyc("post_rst_11_12", 2'b11, 11,12, 0, 0,  32'h0,        0, 0,  0, 0,  2'b11, 2'b00, 32'h0,         32'h0);
    cyc("post_rst_7_9",   2'b11, 7, 9,  0, 0,  32'h0,        0, 0,  0, 0,  2'b11, 2'b00, 32'h0,         32'h0);
    cyc("post_rst_10",    2'b01, 10,0,  0, 0,  32'h0,        0, 0,  0, 0,  2'b01, 2'b00, 32'h0,         32'h0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_responses: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
